// File: rtl/sw_out_arb.sv
// Output-port arbiter: round-robin grant held until TAIL, 1-cycle registered flit mux.
// Backpressure is request-driven; the ack drops on a TAIL, on a dropped owner req, or during rst.
module sw_out_arb #(
  parameter int NPORT = 5,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORT-1:0]          req_i,
  output logic [NPORT-1:0]          ack_o,
  input  logic [NPORT*(DW+2)-1:0]   in_flit_i,
  input  logic [NPORT-1:0]          in_vld_i,
  output logic [DW+1:0]             out_flit_o,
  output logic                      out_vld_o,
  output logic [$clog2(NPORT)-1:0]  owner_o,
  output logic                      busy_o,
  output logic [15:0]               pkt_cnt_o
);

  localparam int IW = $clog2(NPORT);
  localparam int FW = DW + 2;
  localparam logic [1:0] TAIL = 2'b11;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   rr_d;
  logic [FW-1:0]   out_flit_q;
  logic            out_vld_q;
  logic [15:0]     pkt_cnt_q;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic            grant_cyc;
  logic            owner_req;
  logic [IW-1:0]   sel;
  logic [FW-1:0]   sel_flit;
  logic            fwd;
  logic            is_tail;
  logic            abort;

  // First requester at or above rr_q, wrapping modulo NPORT.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NPORT; k++) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= NPORT) j = j - NPORT;
      if (!win_vld && req_i[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  assign grant_cyc = (state_q == IDLE) && win_vld && !rst;
  assign owner_req = req_i[owner_q];
  assign sel       = grant_cyc ? win_idx : owner_q;
  assign sel_flit  = in_flit_i[FW*int'(sel) +: FW];
  assign fwd       = in_vld_i[sel] && (grant_cyc || state_q == BUSY);
  assign is_tail   = fwd && (sel_flit[FW-1 -: 2] == TAIL);
  assign abort     = (state_q == BUSY) && !owner_req && !is_tail;
  assign rr_d      = (sel == IW'(NPORT-1)) ? '0 : sel + IW'(1);

  always_comb begin
    ack_o = '0;
    if (!rst) begin
      if (grant_cyc)
        ack_o[win_idx] = 1'b1;
      else if (state_q == BUSY && owner_req)
        ack_o[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      out_flit_q <= '0;
      out_vld_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      out_vld_q <= fwd;
      if (fwd) out_flit_q <= sel_flit;
      if (grant_cyc) owner_q <= win_idx;
      // A single-flit packet (TAIL in the grant cycle) never enters BUSY.
      case (state_q)
        IDLE:    if (grant_cyc && !is_tail) state_q <= BUSY;
        BUSY:    if (is_tail || !owner_req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (is_tail || abort) rr_q <= rr_d;
      if (is_tail) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign out_flit_o = out_flit_q;
  assign out_vld_o  = out_vld_q;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q == BUSY);
  assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_sw_out_arb.sv
// Randomized and directed checks of sw_out_arb against a packet-level reference model.
module tb_sw_out_arb;
  localparam int NPORT = 5;
  localparam int DW    = 32;
  localparam int FW    = DW + 2;
  localparam logic [1:0] HEAD = 2'b01, BODY = 2'b10, TAIL = 2'b11;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NPORT-1:0]        req;
  logic [NPORT-1:0]        ack;
  logic [NPORT*FW-1:0]     in_flit;
  logic [NPORT-1:0]        in_vld;
  logic [FW-1:0]           out_flit;
  logic                    out_vld;
  logic [2:0]              owner;
  logic                    busy;
  logic [15:0]             pkt_cnt;

  sw_out_arb #(.NPORT(NPORT), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_i(req), .ack_o(ack), .in_flit_i(in_flit),
    .in_vld_i(in_vld), .out_flit_o(out_flit), .out_vld_o(out_vld),
    .owner_o(owner), .busy_o(busy), .pkt_cnt_o(pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who holds the port, the pointer, the count and the output register.
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  logic [15:0] m_cnt;
  logic [FW-1:0] m_flit;
  bit          m_vld;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic tick(input bit full);
    logic [NPORT-1:0] eack;
    logic [FW-1:0]    f;
    bit grant, act, v;
    int gidx, sel;
    #1;
    eack = '0; grant = 0; act = 0; gidx = 0; sel = m_owner;
    if (!rst) begin
      if (!m_busy) begin
        for (int k = 0; k < NPORT; k++)
          if (!grant && req[(m_ptr + k) % NPORT]) begin
            grant = 1;
            gidx  = (m_ptr + k) % NPORT;
          end
        if (grant) begin eack[gidx] = 1'b1; sel = gidx; act = 1; end
      end else begin
        act = 1;
        if (req[m_owner]) eack[m_owner] = 1'b1;
      end
    end
    check("ack", ack, eack);
    check("pkt_cnt", pkt_cnt, m_cnt);
    if (full) begin
      check("busy", busy, m_busy);
      if (m_busy) check("owner", owner, m_owner);
      check("out_vld", out_vld, m_vld);
      check("out_flit", out_flit, m_flit);
      check("ack_onehot", ($countones(ack) <= 1), 1);
      check("ack_no_req", ack & ~req, 0);
    end
    f = in_flit[sel*FW +: FW];
    v = act && in_vld[sel];
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_flit = '0; m_vld = 0;
    end else begin
      m_vld = v;
      if (v) m_flit = f;
      if (v && f[FW-1 -: 2] == TAIL) begin
        m_busy = 0; m_ptr = (sel + 1) % NPORT; m_cnt = m_cnt + 16'd1;
      end else if (grant) begin
        m_busy = 1; m_owner = gidx;
      end else if (m_busy && !req[m_owner]) begin
        m_busy = 0; m_ptr = (m_owner + 1) % NPORT;
      end
    end
    @(negedge clk);
  endtask

  task automatic put(input int p, input logic [1:0] t, input logic [DW-1:0] d);
    in_vld[p] = 1'b1;
    in_flit[p*FW +: FW] = {t, d};
  endtask

  function automatic int idx_of(input logic [NPORT-1:0] a, input int dflt);
    for (int i = 0; i < NPORT; i++) if (a[i]) return i;
    return dflt;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = '1; in_vld = '1; in_flit = '1;
    tick(1);
    tick(1);
    rst = 1'b0; req = '0; in_vld = '0; in_flit = '0;
  endtask

  initial begin
    int order[4];
    int w;
    logic [15:0] cnt_save;
    logic [NPORT-1:0] rq;
    order = '{0, 1, 4, 0};
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_flit = '0; m_vld = 0;
    rst = 1'b1; req = '0; in_vld = '0; in_flit = '0;
    @(negedge clk);
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_vld", out_vld, 0);
    check("rst_flit", out_flit, 0);
    check("rst_cnt", pkt_cnt, 0);

    // Single grant: HEAD/BODY/TAIL from input 2.
    req = 5'b00100; in_vld = '0; put(2, HEAD, 32'hA0);
    #1 check("sg_ack", ack, 5'b00100);
    tick(1);
    in_vld = '0; put(2, BODY, 32'hA1);
    check("sg_out0", out_flit, {HEAD, 32'hA0});
    tick(1);
    in_vld = '0; put(2, TAIL, 32'hA2);
    check("sg_out1", out_flit, {BODY, 32'hA1});
    check("sg_ack_tail", ack, 5'b00100);
    tick(1);
    req = '0; in_vld = '0;
    check("sg_out2", out_flit, {TAIL, 32'hA2});
    check("sg_cnt", pkt_cnt, 1);
    check("sg_idle", busy, 0);
    tick(1);

    // Round-robin with req held: 0, 1, 4, 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 5'b10011; in_vld = '0;
      #1 check("rr_grant", ack, 5'b00001 << order[i]);
      check("rr_idle_gap", busy, 0);
      w = idx_of(ack, order[i]);
      put(w, HEAD, 32'h100 + i);
      tick(1);
      in_vld = '0; put(w, TAIL, 32'h200 + i);
      check("rr_busy", busy, 1);
      tick(1);
    end

    // Isolation: input 1 owns, input 3 is requesting and driving flits.
    req = 5'b00010; in_vld = '0; put(1, HEAD, 32'h11);
    tick(1);
    for (int k = 0; k < 3; k++) begin
      req = 5'b01010; in_vld = '0;
      put(1, (k == 2) ? TAIL : BODY, 32'h12 + k);
      put(3, BODY, 32'hBAD30 + k);
      #1 check("iso_ack3", ack[3], 0);
      tick(1);
    end
    req = 5'b01000; in_vld = '0;
    check("iso_last", out_flit, {TAIL, 32'h14});
    #1 check("iso_next", ack, 5'b01000);
    tick(1);
    req = '0;
    tick(1);

    // Abort: owner 0 drops req after HEAD, BODY.
    do_reset();
    req = 5'b00001; in_vld = '0; put(0, HEAD, 32'h50);
    tick(1);
    in_vld = '0; put(0, BODY, 32'h51);
    tick(1);
    cnt_save = pkt_cnt;
    req = 5'b00010; in_vld = '0;
    #1 check("ab_ack", ack, 0);
    tick(1);
    #1 check("ab_next", ack, 5'b00010);
    check("ab_cnt", pkt_cnt, cnt_save);
    tick(1);
    req = '0;
    tick(1);

    // Reset mid-packet, then a fresh grant.
    req = 5'b00100; in_vld = '0; put(2, HEAD, 32'h60);
    tick(1);
    rst = 1'b1; in_vld = '0; put(2, BODY, 32'h61);
    #1 check("rm_ack", ack, 0);
    tick(1);
    rst = 1'b0; req = '0; in_vld = '0;
    check("rm_busy", busy, 0);
    check("rm_vld", out_vld, 0);
    check("rm_cnt", pkt_cnt, 0);
    req = 5'b01000;
    #1 check("rm_fresh", ack, 5'b01000);
    tick(1);
    req = '0;
    tick(1);

    // Random traffic with persistent requests and occasional reset.
    rq = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NPORT; p++) begin
        if ($urandom_range(5) == 0) rq[p] = ~rq[p];
        in_vld[p] = ($urandom_range(2) != 0);
        in_flit[p*FW +: FW] = {2'($urandom_range(3)), 32'($urandom)};
      end
      req = rq;
      rst = ($urandom_range(299) == 0);
      tick(1);
    end
    rst = 1'b0;

    // Counter wrap: 65536 single-flit packets.
    do_reset();
    req = 5'b00001;
    for (int i = 0; i < 65536; i++) begin
      in_vld = '0; put(0, TAIL, 32'(i));
      if (i == 65535) check("wrap_max", pkt_cnt, 16'hFFFF);
      tick(0);
    end
    req = '0; in_vld = '0;
    check("wrap_zero", pkt_cnt, 0);
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sw_out_arb.md
Name: sw_out_arb

Overview:
- Output-port side of the switch request/ack handshake: the responder that the per-input request state machines talk to.
- One instance per output port. It collects per-input request bits, grants exactly one input by round-robin, and holds that grant until the packet's TAIL flit has passed.
- It muxes the granted input's flits onto a registered output channel and counts forwarded packets.

Parameters:
- NPORT, 5, number of input ports competing for this output.
- DW, 32, flit payload width, excluding the 2-bit type field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- req  in  NPORT  per-input request for this output; bit i is driven by input i's request state machine.
- ack  out  NPORT  one-hot grant; combinational in the grant cycle, then held.
- in_flit  in  NPORT*(DW+2)  flattened flits; slice i = {type[1:0], data[DW-1:0]} from input i's FIFO head.
- in_vld  in  NPORT  input i's flit is valid this cycle (its re & !empty).
- out_flit  out  DW+2  registered forwarded flit.
- out_vld  out  1  registered valid for out_flit.
- owner  out  $clog2(NPORT)  index of the current grant holder; meaningful only when busy=1.
- busy  out  1  an input holds this output.
- pkt_cnt  out  16  count of TAIL flits forwarded; wraps at 2^16.

Behaviour:
- Type encoding: NONE=2'b00, HEAD=2'b01, BODY=2'b10, TAIL=2'b11.
- Reset values: state=IDLE, ack=0 (forced 0 while rst=1 regardless of req), out_flit=0, out_vld=0, owner=0, busy=0, pkt_cnt=0, rr pointer=0.
- FSM states: IDLE and BUSY.
- IDLE:
  - If req!=0, ack = one-hot of the first set req bit searching from rr_ptr upward, wrapping modulo NPORT.
  - Grant is combinational in the same cycle, so the requester can enter transfer and assert re that cycle.
  - Next state BUSY; owner <= winner index.
  - If req==0, ack=0 and the FSM stays in IDLE.
- BUSY:
  - ack = onehot(owner) while req[owner]=1; all other ack bits are 0.
  - Requests from other inputs are ignored.
- Flit select: sel = the granted index in the grant cycle, else owner.
- Output register: each cycle, out_vld <= in_vld[sel] & (grant cycle or BUSY); out_flit <= in_flit slice sel when valid, otherwise it holds its value.
  - Latency: 1 cycle from input flit to out_flit.
  - Flits of non-owners never appear on the output.
- Release on TAIL: a valid TAIL from sel (grant cycle or BUSY) gives next state IDLE, rr_ptr <= (sel+1) mod NPORT, and pkt_cnt increments.
  - ack stays asserted during the TAIL cycle and drops the following cycle.
- Abort release: req[owner]=0 while BUSY gives ack=0 that cycle, next state IDLE, rr_ptr <= owner+1, and no pkt_cnt increment.
- Back-to-back packets: a requester that re-requests right after its TAIL competes again in IDLE, and other requesters win first because the pointer has advanced past it. There is no dead cycle beyond the single IDLE arbitration cycle.
- HEAD is not checked for arbitration; arbitration is request-driven. A flit of type NONE that is marked valid is forwarded unchanged.
- If TAIL and a req drop coincide, TAIL takes priority: pkt_cnt counts, and the pointer advances the same way.
- Reset mid-packet: the FSM returns to IDLE next cycle, ack is 0 during rst, out_vld=0, and any partial packet is dropped without error.
- At most one ack bit is ever set. ack is never asserted to an input whose req=0.

Test Plan:
- Single grant:
  - Stimulus: after reset, req=5'b00100; input 2 sends HEAD, BODY, TAIL on consecutive cycles.
  - Required: ack=5'b00100 in the same cycle; out_flit equals each flit one cycle later; pkt_cnt=1; ack=0 the cycle after TAIL.
- Round-robin:
  - Stimulus: req=5'b10011 held continuously; each granted input sends a 2-flit packet.
  - Required: grant order 0, 1, 4, 0; each ack is one-hot; there is exactly one IDLE cycle between packets.
- Isolation:
  - Stimulus: input 1 owns the output; input 3 asserts req and drives valid flits.
  - Required: ack[3]=0 until input 1's TAIL; no input-3 data appears on out_flit before then.
- Abort:
  - Stimulus: owner 0 drops req mid-packet after HEAD and BODY.
  - Required: ack=0 in the same cycle; pkt_cnt unchanged; next grant goes to input 1 if requesting.
- Reset mid-packet:
  - Stimulus: assert rst while BUSY.
  - Required: ack=0, busy=0, out_vld=0, pkt_cnt=0 the next cycle; a fresh request after reset is granted normally.
- Wrap:
  - Stimulus: preload by forwarding 65536 single TAIL-terminated packets.
  - Required: pkt_cnt wraps to 0.
